tile_ram_arbiter: RTL and testbench

Time-shares the single-port 32x32-byte tile RAM (`RAM_sync`, 1-cycle read latency) between three requesters: video scan-out (absolute priority), the map-initialisation streamer, and a CPU-side request/acknowledge port. It sits between the tile RAM and its clients in the pacman top level. It replaces the fixed `init ? video : evaluator` address mux, so the CPU can read and write cells (pellet removal) during blanking.

---
 rtl/tile_ram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_tile_ram_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_ram_arbiter.sv
// tile_ram_arbiter
//
// Time-shares the single-port tile RAM (1-cycle read latency) between three
// clients, in priority order:
//   1. video scan-out (absolute; owns the RAM whenever vid_active is high)
//   2. the map-initialisation streamer (bounded burst while the CPU waits)
//   3. a CPU request/acknowledge port (single read or write per request)
//
// Optional build macro:
//   TILE_ARB_STATS_EN  - when defined, stall_count counts CPU wait cycles
//                        (saturating). When undefined, stall_count is tied 0.
//
// Ports:
//   clk, reset               system clock, synchronous active-high reset
//   vid_active, vid_addr     video ownership and fetch address
//   init_req/addr/din/we     init streamer request and write port
//   init_gnt                 init access performed this cycle
//   cpu_req/we/addr/din      CPU request, held until cpu_ack
//   cpu_ack, cpu_dout        completion pulse and read data
//   ram_addr/din/we          RAM command
//   ram_dout                 RAM read data (also used directly by the renderer)
//   stall_count              CPU wait-cycle counter
module tile_ram_arbiter #(
  parameter int INIT_BURST = 16,
  parameter int AW         = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_active,
  input  logic [AW-1:0] vid_addr,
  input  logic          init_req,
  input  logic [AW-1:0] init_addr,
  input  logic [7:0]    init_din,
  input  logic          init_we,
  output logic          init_gnt,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          cpu_ack,
  output logic [7:0]    cpu_dout,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout,
  output logic [15:0]   stall_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_CPU_WR  = 3'd2;
  localparam logic [2:0] S_CPU_RD  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_ACK     = 3'd5;

  localparam int         BW        = (INIT_BURST < 1) ? 1 : $clog2(INIT_BURST + 1);
  localparam logic [BW:0] BURST_LIM = (BW+1)'(INIT_BURST);

  logic [2:0]    state, state_nxt;
  logic [BW-1:0] burst_cnt;
  logic [BW:0]   burst_nxt;
  logic          burst_hit;
  logic          cpu_take;
  logic [AW-1:0] cap_addr;
  logic [7:0]    cap_din;

  assign init_gnt = (state == S_INIT) && !vid_active;
  assign cpu_ack  = (state == S_ACK);

  // Burst count including this cycle's grant, so the CPU slot is forced
  // right after the INIT_BURST-th init access rather than one access later.
  assign burst_nxt = {1'b0, burst_cnt} + {{BW{1'b0}}, init_gnt};
  assign burst_hit = cpu_req && (burst_nxt >= BURST_LIM);

  // A CPU request is captured either from IDLE (video and init both quiet)
  // or when the init burst limit forces a CPU slot.
  assign cpu_take = ((state == S_IDLE) && !vid_active && !init_req && cpu_req) ||
                    ((state == S_INIT) && burst_hit);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!vid_active) begin
          if (init_req)     state_nxt = S_INIT;
          else if (cpu_req) state_nxt = cpu_we ? S_CPU_WR : S_CPU_RD;
        end
      end
      S_INIT: begin
        if (burst_hit)      state_nxt = cpu_we ? S_CPU_WR : S_CPU_RD;
        else if (!init_req) state_nxt = S_IDLE;
      end
      S_CPU_WR:  if (!vid_active) state_nxt = S_ACK;
      S_CPU_RD:  if (!vid_active) state_nxt = S_RD_WAIT;
      S_RD_WAIT: state_nxt = S_ACK;
      S_ACK:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // RAM command mux; video always overrides whatever the FSM is doing.
  always_comb begin
    ram_addr = vid_addr;
    ram_din  = cap_din;
    ram_we   = 1'b0;
    if (!vid_active) begin
      case (state)
        S_INIT: begin
          ram_addr = init_addr;
          ram_din  = init_din;
          ram_we   = init_we;
        end
        S_CPU_WR: begin
          ram_addr = cap_addr;
          ram_we   = 1'b1;
        end
        S_CPU_RD: ram_addr = cap_addr;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!cpu_req || cpu_take)
        burst_cnt <= '0;
      else if (init_gnt)
        burst_cnt <= burst_nxt[BW-1:0];
    end
  end

  // Captured request; no reset needed, only read in CPU_WR/CPU_RD.
  always_ff @(posedge clk) begin
    if (cpu_take) begin
      cap_addr <= cpu_addr;
      cap_din  <= cpu_din;
    end
  end

  // RD_WAIT is the cycle ram_dout holds the CPU address's data, even if
  // video has since taken the RAM address.
  always_ff @(posedge clk) begin
    if (reset)
      cpu_dout <= 8'h00;
    else if (state == S_RD_WAIT)
      cpu_dout <= ram_dout;
  end

`ifdef TILE_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic stall_cyc;
  assign stall_cyc = cpu_req &&
                     ((state == S_IDLE) || (state == S_INIT) ||
                      (((state == S_CPU_WR) || (state == S_CPU_RD)) && vid_active));

  always_ff @(posedge clk) begin
    if (reset)
      stall_count <= 16'h0000;
    else if (stall_cyc)
      stall_count <= sat_inc16(stall_count);
  end
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Self-checking bench for tile_ram_arbiter: a table of CPU accesses with
// per-entry video interference, plus hand-written sequences for reset during
// a read, init fairness, init/CPU priority and the stall counter.
module tb_tile_ram_arbiter;
  localparam int AW = 10;
  localparam int INIT_BURST = 16;
`ifdef TILE_ARB_STATS_EN
  localparam int EXP_STALL = 11;  // granting IDLE cycle + 10 retried CPU_RD cycles
`else
  localparam int EXP_STALL = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, vid_active, init_req, init_we, cpu_req, cpu_we;
  logic [AW-1:0] vid_addr, init_addr, cpu_addr, ram_addr;
  logic [7:0]    init_din, cpu_din, cpu_dout, ram_din, ram_dout;
  logic          init_gnt, cpu_ack, ram_we;
  logic [15:0]   stall_count;

  tile_ram_arbiter #(.INIT_BURST(INIT_BURST), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .vid_active(vid_active), .vid_addr(vid_addr),
    .init_req(init_req), .init_addr(init_addr), .init_din(init_din),
    .init_we(init_we), .init_gnt(init_gnt),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .stall_count(stall_count)
  );

  // Single-port RAM with 1-cycle read latency.
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    din;
    int            vc;       // video cycles during the CPU_WR/CPU_RD slot
    logic          vrd;      // video also owns the RAM during RD_WAIT
    logic [7:0]    exp_dout;
  } vec_t;

  typedef struct { bit rd; logic [7:0] dout; int cyc; } exp_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [7:0] din; } wr_t;

  exp_t sb_q[$];
  wr_t  wr_q[$];
  vec_t tbl [9];

  int n_pass = 0, n_total = 0;
  int cyc = 0, ack_cnt = 0, gnt_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Observe the current cycle at the falling edge, then advance one cycle.
  task automatic tick();
    exp_t e;
    wr_t  w;
    @(negedge clk);
    if (!reset) begin
      if (vid_active) begin
        check("vid_we", 32'(ram_we), 32'(0));
        check("vid_addr", 32'(ram_addr), 32'(vid_addr));
      end
      if (ram_we && !init_gnt) begin
        if (wr_q.size() == 0) check("stray_write", 32'(ram_we), 32'(0));
        else begin
          w = wr_q.pop_front();
          check("wr_cycle", 32'(cyc), 32'(w.cyc));
          check("wr_addr", 32'(ram_addr), 32'(w.addr));
          check("wr_data", 32'(ram_din), 32'(w.din));
        end
      end
      if (cpu_ack) begin
        ack_cnt++;
        if (sb_q.size() == 0) check("stray_ack", 32'(cpu_ack), 32'(0));
        else begin
          e = sb_q.pop_front();
          check("ack_cycle", 32'(cyc), 32'(e.cyc));
          if (e.rd) check("rd_data", 32'(cpu_dout), 32'(e.dout));
        end
      end
      if (init_gnt) gnt_cnt++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Tick while acting as the init streamer: advance only after a grant.
  task automatic init_tick();
    int g0;
    g0 = gnt_cnt;
    tick();
    if (gnt_cnt != g0) begin
      init_addr = init_addr + AW'(1);
      init_din  = init_din + 8'd1;
    end
  endtask

  // Wait for the ack, then drop cpu_req in the cycle after it.
  task automatic wait_ack(input int a0, input string name);
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      init_tick();
      if (ack_cnt != a0) done = 1;
    end
    cpu_req = 1'b0;
    if (!done) begin
      check(name, 32'(ack_cnt), 32'(a0 + 1));
      sb_q.delete();
      wr_q.delete();
    end
  endtask

  // Issue one CPU access from an IDLE cycle; returns in the cycle after ACK.
  task automatic issue(input vec_t v);
    int k, t, a0;
    bit done;
    exp_t e;
    wr_t  w;
    k = cyc;
    a0 = ack_cnt;
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_din = v.din;
    vid_active = 1'b0;
    e.rd = !v.we; e.dout = v.exp_dout; e.cyc = k + (v.we ? 2 : 3) + v.vc;
    sb_q.push_back(e);
    if (v.we) begin
      w.cyc = k + 1 + v.vc; w.addr = v.addr; w.din = v.din;
      wr_q.push_back(w);
    end
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      t = cyc - k;
      if (ack_cnt != a0) done = 1;
      vid_active = !done && ((t >= 1 && t <= v.vc) || (v.vrd && !v.we && t == v.vc + 2));
      vid_addr = AW'(10'h200 + t);
    end
    cpu_req = 1'b0;
    vid_active = 1'b0;
    if (!done) begin
      check("ack_timeout", 32'(ack_cnt), 32'(a0 + 1));
      sb_q.delete();
      wr_q.delete();
    end
  endtask

  initial begin
    int b, c, k, g0, a0;
    exp_t e;
    wr_t  w;
    vec_t v;

    //               we    addr     din    vc vrd  exp_dout
    tbl[0] = '{1'b1, 10'h123, 8'h5A, 0,  1'b0, 8'h00};
    tbl[1] = '{1'b0, 10'h123, 8'h00, 0,  1'b0, 8'h5A};
    tbl[2] = '{1'b1, 10'h050, 8'h77, 4,  1'b0, 8'h00};
    tbl[3] = '{1'b0, 10'h050, 8'h00, 2,  1'b0, 8'h77};
    tbl[4] = '{1'b1, 10'h3FF, 8'hA5, 0,  1'b0, 8'h00};
    tbl[5] = '{1'b0, 10'h3FF, 8'h00, 0,  1'b0, 8'hA5};
    tbl[6] = '{1'b1, 10'h000, 8'hFF, 1,  1'b0, 8'h00};
    tbl[7] = '{1'b0, 10'h000, 8'h00, 1,  1'b1, 8'hFF};
    tbl[8] = '{1'b0, 10'h123, 8'h00, 0,  1'b0, 8'h5A};

    reset = 1'b1; vid_active = 1'b0; vid_addr = 10'h200;
    init_req = 1'b0; init_addr = 10'h300; init_din = 8'h10; init_we = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    @(posedge clk); #1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("rst_cpu_ack", 32'(cpu_ack), 32'(0));
    check("rst_cpu_dout", 32'(cpu_dout), 32'(0));
    check("rst_init_gnt", 32'(init_gnt), 32'(0));
    check("rst_ram_we", 32'(ram_we), 32'(0));
    check("rst_stall", 32'(stall_count), 32'(0));

    // Back-to-back table: each access starts in the IDLE cycle after the ACK.
    for (int i = 0; i < 9; i++) issue(tbl[i]);

    // Init fairness: 16 grants, then the pending CPU read, then init resumes.
    init_req = 1'b1; init_we = 1'b1;
    repeat (3) init_tick();
    b = cyc; g0 = gnt_cnt; a0 = ack_cnt;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h123;
    e.rd = 1'b1; e.dout = 8'h5A; e.cyc = b + INIT_BURST + 2;
    sb_q.push_back(e);
    wait_ack(a0, "fair_ack_timeout");
    check("fair_gnt_count", 32'(gnt_cnt - g0), 32'(INIT_BURST));
    init_tick();
    init_tick();
    check("fair_resume", 32'(gnt_cnt - g0), 32'(INIT_BURST + 1));
    init_req = 1'b0; init_we = 1'b0;
    init_tick();

    // Priority: init and CPU rise together in IDLE; init wins until it drops.
    c = cyc; g0 = gnt_cnt; a0 = ack_cnt;
    init_req = 1'b1; init_we = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h0AB; cpu_din = 8'hC3;
    init_tick();
    init_tick();
    check("prio_init_first", 32'(gnt_cnt - g0), 32'(1));
    repeat (3) init_tick();
    init_req = 1'b0; init_we = 1'b0;
    e.rd = 1'b0; e.dout = 8'h00; e.cyc = c + 8;
    sb_q.push_back(e);
    w.cyc = c + 7; w.addr = 10'h0AB; w.din = 8'hC3;
    wr_q.push_back(w);
    wait_ack(a0, "prio_ack_timeout");
    check("prio_gnt_count", 32'(gnt_cnt - g0), 32'(5));

    // Reset while the read waits in RD_WAIT: no ack, cpu_dout cleared.
    k = cyc; a0 = ack_cnt;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h050;
    tick();
    tick();
    reset = 1'b1; cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("rstrd_cpu_dout", 32'(cpu_dout), 32'(0));
    check("rstrd_cpu_ack", 32'(cpu_ack), 32'(0));
    check("rstrd_init_gnt", 32'(init_gnt), 32'(0));
    repeat (5) tick();
    check("rstrd_no_ack", 32'(ack_cnt - a0), 32'(0));
    v = '{1'b1, 10'h001, 8'h3C, 0, 1'b0, 8'h00};
    issue(v);
    v = '{1'b0, 10'h001, 8'h00, 0, 1'b0, 8'h3C};
    issue(v);

    // Stall counter: clear, then a read held off by video for 10 cycles.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    v = '{1'b0, 10'h123, 8'h00, 10, 1'b0, 8'h5A};
    issue(v);
    check("stall_count", 32'(stall_count), 32'(EXP_STALL));

    check("sb_empty", 32'(sb_q.size()), 32'(0));
    check("wr_empty", 32'(wr_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
